// File: rtl/ifu_prefetch_pkg.sv
// Shared widths, reset PC and the fetch-entry record used by the prefetch front end.
// Pure declarations: no latency, no flow control.
package ifu_prefetch_pkg;

  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_RST = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
    logic              filled;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifu_prefetch_fetch_ring_buffer.sv
// Ring of fetch entries with alloc/fill/head pointers; head entry is read straight from flops.
// Caller never allocates when full or pops when empty; flush rewinds alloc and fill onto head.
module ifu_prefetch_fetch_ring_buffer
  import ifu_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_vld,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              alloc_fault,
  input  logic              fill_vld,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              fill_err,
  input  logic              pop,
  output fetch_entry_t      head_ent,
  output logic [PW-1:0]     used,
  output logic [PW-1:0]     live
);

  localparam int IW = $clog2(DEPTH);

  fetch_entry_t ent_q [DEPTH];
  fetch_entry_t ent_d [DEPTH];
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;
  logic [IW-1:0] alloc_idx, fill_idx, head_idx, last_idx;
  logic          tail_synth;

  assign alloc_idx = alloc_q[IW-1:0];
  assign fill_idx  = fill_q[IW-1:0];
  assign head_idx  = head_q[IW-1:0];
  assign last_idx  = alloc_idx - IW'(1);

  // A synthetic fault entry is pre-filled and can only be the youngest allocation,
  // so it sits between fill and alloc without being a memory request.
  assign tail_synth = (alloc_q != fill_q) && ent_q[last_idx].filled;
  assign live       = (alloc_q - fill_q) - PW'(tail_synth);
  assign used       = alloc_q - head_q;
  assign head_ent   = ent_q[head_idx];

  always_comb begin
    ent_d   = ent_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    if (flush) begin
      alloc_d = head_q;
      fill_d  = head_q;
    end else begin
      if (alloc_vld) begin
        ent_d[alloc_idx].pc     = alloc_pc;
        ent_d[alloc_idx].inst   = '0;
        ent_d[alloc_idx].fault  = alloc_fault;
        ent_d[alloc_idx].filled = alloc_fault;
        alloc_d = alloc_q + PW'(1);
      end
      if (fill_vld) begin
        ent_d[fill_idx].inst   = fill_inst;
        ent_d[fill_idx].fault  = fill_err;
        ent_d[fill_idx].filled = 1'b1;
        fill_d = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Decoupled fetch stage: owns fetch PC, issues in-order imem requests, hands {pc, inst, fault} to decode.
// Response-to-decode latency 1 cycle; issue stalls while buffered plus stale requests fill DEPTH credits.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_inst,
  input  logic              imem_resp_err,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault,
  output logic [XLEN-1:0]   fetch_pc
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            halted_q, halted_d;
  logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   used, live, drop_sum;
  fetch_entry_t    head_ent;
  logic            aligned, space, issue_ok, req_fire, mis_alloc, resp_fill, pop;

  // Stale requests still hold memory slots, so they count against the same credits.
  assign space     = ({1'b0, used} + {1'b0, drop_cnt_q}) < CAP;
  assign aligned   = (fetch_pc_q[1:0] == 2'b00);
  assign issue_ok  = !rst && !redirect_valid && !halted_q && space;
  assign mis_alloc = issue_ok && !aligned;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_fill = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0) && (live != '0);
  assign pop       = inst_valid && inst_ready;
  assign drop_sum  = drop_cnt_q + live;

  assign imem_req_valid = issue_ok && aligned;
  assign imem_req_addr  = fetch_pc_q;
  assign fetch_pc       = fetch_pc_q;
  assign inst_valid     = head_ent.filled && (used != '0) && !redirect_valid;
  assign inst_out       = head_ent.inst;
  assign inst_pc        = head_ent.pc;
  assign inst_fault     = head_ent.fault;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      drop_cnt_d = (imem_resp_valid && (drop_sum != '0)) ? drop_sum - PW'(1) : drop_sum;
    end else begin
      if (req_fire) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end
      if (mis_alloc || (resp_fill && imem_resp_err)) begin
        halted_d = 1'b1;
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= PC_RST;
      halted_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifu_prefetch_fetch_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc_vld  (req_fire || mis_alloc),
    .alloc_pc   (fetch_pc_q),
    .alloc_fault(mis_alloc),
    .fill_vld   (resp_fill),
    .fill_inst  (imem_resp_inst),
    .fill_err   (imem_resp_err),
    .pop        (pop),
    .head_ent   (head_ent),
    .used       (used),
    .live       (live)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: vector table for reset/streaming/backpressure, directed corner sequences,
// then random traffic against a sequential-program reference model with an in-order memory.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic [63:0] fetch_pc;

  always #5 clk = ~clk;

  ifu_prefetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst), .imem_resp_err(imem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .fetch_pc(fetch_pc)
  );

  typedef struct { logic [63:0] addr; int due; bit stale; } mreq_t;
  typedef struct { bit do_rst; bit rdy; bit e_rv; logic [63:0] e_fpc; bit e_iv; logic [63:0] e_ipc; } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  mreq_t mq[$];
  logic [63:0] req_pc, exp_pc, rd_pc, err_mask, err_match, first_pc;
  bit m_halt, rd_v, iready, err_on, got_first;
  int lat_min, lat_max, mrdy_pct, n_deliv, n_req;
  vec_t tv[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [63:0] a);
    return {a[17:2], ~a[17:2]};
  endfunction

  function automatic bit errf(input logic [63:0] a);
    return err_on && ((a & err_mask) == err_match);
  endfunction

  task automatic model_clear();
    mq.delete();
    req_pc = B; exp_pc = B; m_halt = 0; rd_v = 0; got_first = 0;
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model as the posedge will commit.
  task automatic cycle();
    bit resp_now;
    @(negedge clk);
    cyc++;
    redirect_valid = rd_v;
    redirect_pc    = rd_pc;
    inst_ready     = iready;
    imem_req_ready = ($urandom_range(99, 0) < mrdy_pct);
    resp_now = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_inst  = resp_now ? memf(mq[0].addr) : 32'h0;
    imem_resp_err   = resp_now ? errf(mq[0].addr) : 1'b0;
    #1;
    if (rd_v) begin
      check("redirect_req_valid", 64'(imem_req_valid), 64'd0);
      check("redirect_inst_valid", 64'(inst_valid), 64'd0);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, req_pc);
      check("req_aligned", 64'(imem_req_addr[1:0]), 64'd0);
      check("req_while_halted", 64'(m_halt), 64'd0);
      mq.push_back('{addr: imem_req_addr, due: cyc + 1 + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
      check("credit_bound", 64'(mq.size() <= DEPTH), 64'd1);
      req_pc = req_pc + 64'd4;
      n_req++;
    end
    if (inst_valid && inst_ready) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_out", 64'(inst_out), (exp_pc[1:0] != 2'b00) ? 64'd0 : 64'(memf(exp_pc)));
      check("inst_fault", 64'(inst_fault), (exp_pc[1:0] != 2'b00) ? 64'd1 : 64'(errf(exp_pc)));
      if (!got_first) begin got_first = 1; first_pc = inst_pc; end
      exp_pc = exp_pc + 64'd4;
      n_deliv++;
    end
    if (resp_now) begin
      if (!mq[0].stale && !rd_v && imem_resp_err) m_halt = 1;
      void'(mq.pop_front());
    end
    if (rd_v) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      req_pc = rd_pc; exp_pc = rd_pc; m_halt = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; rd_v = 0;
    redirect_valid = 0; imem_resp_valid = 0; inst_ready = 0; imem_req_ready = 0;
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_fetch_pc", fetch_pc, B);
    check("rst_inst_out", 64'(inst_out), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_inst_fault", 64'(inst_fault), 64'd0);
    @(posedge clk); #2;
    rst = 0;
    model_clear();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    rd_v = 1; rd_pc = pc; got_first = 0;
    cycle();
    rd_v = 0;
  endtask

  initial begin
    int d0, r0;
    rst = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_inst = 0; imem_resp_err = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0; rd_pc = 0; first_pc = 0;
    lat_min = 0; lat_max = 0; mrdy_pct = 100; iready = 1; err_on = 0; err_mask = 0; err_match = 0;
    n_deliv = 0; n_req = 0;
    model_clear();

    // streaming from reset, then a fresh reset with decode stalled for 10 cycles
    tv[0]  = '{1, 1, 1, B + 64'h00, 0, 64'h0};
    tv[1]  = '{0, 1, 1, B + 64'h04, 0, 64'h0};
    tv[2]  = '{0, 1, 1, B + 64'h08, 1, B + 64'h00};
    tv[3]  = '{0, 1, 1, B + 64'h0C, 1, B + 64'h04};
    tv[4]  = '{0, 1, 1, B + 64'h10, 1, B + 64'h08};
    tv[5]  = '{1, 0, 1, B + 64'h00, 0, 64'h0};
    tv[6]  = '{0, 0, 1, B + 64'h04, 0, 64'h0};
    tv[7]  = '{0, 0, 1, B + 64'h08, 1, B + 64'h00};
    tv[8]  = '{0, 0, 1, B + 64'h0C, 1, B + 64'h00};
    for (int i = 9; i < 15; i++) tv[i] = '{0, 0, 0, B + 64'h10, 1, B + 64'h00};
    tv[15] = '{0, 1, 0, B + 64'h10, 1, B + 64'h00};
    tv[16] = '{0, 1, 1, B + 64'h10, 1, B + 64'h04};
    tv[17] = '{0, 1, 1, B + 64'h14, 1, B + 64'h08};
    tv[18] = '{0, 1, 1, B + 64'h18, 1, B + 64'h0C};
    tv[19] = '{0, 1, 1, B + 64'h1C, 1, B + 64'h10};
    for (int i = 0; i < 20; i++) begin
      if (tv[i].do_rst) do_reset();
      iready = tv[i].rdy;
      cycle();
      check($sformatf("vec%0d_req_valid", i), 64'(imem_req_valid), 64'(tv[i].e_rv));
      check($sformatf("vec%0d_fetch_pc", i), fetch_pc, tv[i].e_fpc);
      check($sformatf("vec%0d_inst_valid", i), 64'(inst_valid), 64'(tv[i].e_iv));
      if (tv[i].e_iv) check($sformatf("vec%0d_inst_pc", i), inst_pc, tv[i].e_ipc);
    end

    // redirect with three requests in flight behind a slow memory
    do_reset();
    iready = 1; lat_min = 3; lat_max = 3;
    run(3);
    check("inflight_before_redirect", 64'(mq.size()), 64'd3);
    do_redirect(B + 64'h100);
    run(15);
    check("redirect_got_inst", 64'(got_first), 64'd1);
    check("redirect_first_pc", first_pc, B + 64'h100);

    // misaligned redirect target: one synthetic fault entry, then silence
    do_reset();
    lat_min = 0; lat_max = 0;
    run(3);
    do_redirect(B + 64'h102);
    d0 = n_deliv; r0 = n_req;
    run(10);
    check("misalign_deliveries", 64'(n_deliv - d0), 64'd1);
    check("misalign_pc", first_pc, B + 64'h102);
    check("misalign_no_req", 64'(n_req - r0), 64'd0);
    check("misalign_req_valid_low", 64'(imem_req_valid), 64'd0);
    do_redirect(B + 64'h200);
    run(6);
    check("misalign_recover_pc", first_pc, B + 64'h200);

    // access error on 0x8000_0008 halts issue after the already-sent requests
    do_reset();
    err_on = 1; err_mask = '1; err_match = B + 64'h8;
    d0 = n_deliv; r0 = n_req;
    run(12);
    check("err_req_count", 64'(n_req - r0), 64'd4);
    check("err_deliveries", 64'(n_deliv - d0), 64'd4);
    do_redirect(B + 64'h300);
    run(6);
    check("err_recover_pc", first_pc, B + 64'h300);
    err_on = 0;

    // asynchronous reset between clock edges with two entries buffered
    do_reset();
    iready = 0;
    run(4);
    check("async_pre_inst_valid", 64'(inst_valid), 64'd1);
    #1 rst = 1;
    #1;
    check("async_inst_valid", 64'(inst_valid), 64'd0);
    check("async_fetch_pc", fetch_pc, B);
    check("async_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk); #2;
    rst = 0;
    model_clear();

    // random traffic
    do_reset();
    err_on = 1; err_mask = 64'h3C; err_match = 64'h14;
    lat_min = 0; lat_max = 3; mrdy_pct = 75;
    d0 = n_deliv;
    for (int k = 0; k < 3000; k++) begin
      iready = ($urandom_range(99, 0) < 70);
      if ($urandom_range(24, 0) == 0) begin
        rd_v = 1;
        rd_pc = B + 64'($urandom_range(255, 0)) * 64'd4 + (($urandom_range(7, 0) == 0) ? 64'd2 : 64'd0);
      end
      cycle();
      rd_v = 0;
    end
    check("random_throughput", 64'((n_deliv - d0) > 300), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
